// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite register file: response codes, channel FSM
// states and the byte-lane merge used when committing a strobed write.
package axil_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

  localparam int unsigned MAX_DATA_W = 64;

  // Sized for the widest bus; narrower callers zero-extend and keep the low slice.
  function automatic logic [MAX_DATA_W-1:0] apply_wstrb(
    input logic [MAX_DATA_W-1:0]   old_v,
    input logic [MAX_DATA_W-1:0]   new_v,
    input logic [MAX_DATA_W/8-1:0] strb
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < MAX_DATA_W / 8; b++) begin
      if (strb[b]) begin
        res[b*8 +: 8] = new_v[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_v[b*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_wr_ctrl.sv
// Write-side control: AW/W hold registers, write response FSM and the commit
// strobe (index, data, strobes, OK/error) consumed by the register array.
module axil_wr_ctrl
  import axil_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
  parameter int unsigned         IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                awvalid_i,
  output logic                awready_o,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic                bvalid_o,
  input  logic                bready_i,
  output logic [1:0]          bresp_o,
  output logic                commit_ok_o,
  output logic [IDX_W-1:0]    commit_idx_o,
  output logic [DATA_W-1:0]   commit_data_o,
  output logic [DATA_W/8-1:0] commit_strb_o
);

  localparam int unsigned LSB    = $clog2(DATA_W / 8);
  localparam int unsigned STRB_W = DATA_W / 8;

  wr_state_t           state_q;
  logic                aw_held_q, w_held_q, awready_q, wready_q, bvalid_q;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  resp_t               bresp_q;

  logic                aw_hs_s, w_hs_s, commit_s, in_range_s, ok_s;
  logic [ADDR_W-1:0]   addr_s, word_s;
  logic [DATA_W-1:0]   data_s;
  logic [STRB_W-1:0]   strb_s;
  logic [IDX_W-1:0]    idx_s;

  // Held values take priority over the live bus so either arrival order works.
  always_comb begin
    aw_hs_s    = awvalid_i && awready_q;
    w_hs_s     = wvalid_i && wready_q;
    addr_s     = aw_held_q ? awaddr_q : awaddr_i;
    data_s     = w_held_q ? wdata_q : wdata_i;
    strb_s     = w_held_q ? wstrb_q : wstrb_i;
    word_s     = addr_s >> LSB;
    idx_s      = word_s[IDX_W-1:0];
    in_range_s = (word_s < ADDR_W'(NUM_REGS));
    ok_s       = in_range_s && !RO_MASK[idx_s];
    commit_s   = (state_q == W_IDLE) && (aw_held_q || aw_hs_s) && (w_held_q || w_hs_s);
  end

  // Write FSM with hold registers; READY flags are registered and rise one cycle after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (state_q)
        W_IDLE: begin
          if (commit_s) begin
            state_q   <= W_RESP;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= ok_s ? RESP_OKAY : RESP_SLVERR;
          end else begin
            if (aw_hs_s) begin
              aw_held_q <= 1'b1;
              awaddr_q  <= awaddr_i;
            end
            if (w_hs_s) begin
              w_held_q <= 1'b1;
              wdata_q  <= wdata_i;
              wstrb_q  <= wstrb_i;
            end
            awready_q <= !(aw_held_q || aw_hs_s);
            wready_q  <= !(w_held_q || w_hs_s);
          end
        end
        W_RESP: begin
          if (bready_i) begin
            state_q   <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: begin
          state_q   <= W_IDLE;
          bvalid_q  <= 1'b0;
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign awready_o     = awready_q;
  assign wready_o      = wready_q;
  assign bvalid_o      = bvalid_q;
  assign bresp_o       = bresp_q;
  assign commit_ok_o   = commit_s && ok_s;
  assign commit_idx_o  = idx_s;
  assign commit_data_o = data_s;
  assign commit_strb_o = strb_s;

endmodule

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite CSR endpoint: NUM_REGS x DATA_W register array with read-only
// slots sourced from hardware, strobed writes and SLVERR on bad accesses.
module axil_slave_regfile
  import axil_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [ADDR_W-1:0]            AWADDR,
  input  logic [2:0]                   AWPROT,
  input  logic                         WVALID,
  output logic                         WREADY,
  input  logic [DATA_W-1:0]            WDATA,
  input  logic [DATA_W/8-1:0]          WSTRB,
  output logic                         BVALID,
  input  logic                         BREADY,
  output logic [1:0]                   BRESP,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  input  logic [ADDR_W-1:0]            ARADDR,
  input  logic [2:0]                   ARPROT,
  output logic                         RVALID,
  input  logic                         RREADY,
  output logic [DATA_W-1:0]            RDATA,
  output logic [1:0]                   RRESP,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_rd_data_i,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);

  localparam int unsigned LSB    = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned STRB_W = DATA_W / 8;

  if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("axil_slave_regfile: DATA_W must be 32 or 64");
  end
  if (NUM_REGS < 2) begin : g_bad_num_regs
    $error("axil_slave_regfile: NUM_REGS must be at least 2");
  end

  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  logic [DATA_W-1:0]     hw_s   [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q;
  logic                  commit_ok_s;
  logic [IDX_W-1:0]      commit_idx_s;
  logic [DATA_W-1:0]     commit_data_s;
  logic [STRB_W-1:0]     commit_strb_s;
  logic [MAX_DATA_W-1:0] merged_full_s;

  rd_state_t             rd_state_q;
  logic                  arready_q, rvalid_q;
  logic [DATA_W-1:0]     rdata_q;
  resp_t                 rresp_q;
  logic                  ar_hs_s, ar_in_range_s;
  logic [ADDR_W-1:0]     ar_word_s;
  logic [IDX_W-1:0]      ar_idx_s;
  logic [DATA_W-1:0]     rd_val_s;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_o[i*DATA_W +: DATA_W] = regs_q[i];
    assign hw_s[i]                    = hw_rd_data_i[i*DATA_W +: DATA_W];
  end

  axil_wr_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .RO_MASK  (RO_MASK),
    .IDX_W    (IDX_W)
  ) u_wr_ctrl (
    .clk_i         (ACLK),
    .rst_i         (ARESET),
    .awvalid_i     (AWVALID),
    .awready_o     (AWREADY),
    .awaddr_i      (AWADDR),
    .wvalid_i      (WVALID),
    .wready_o      (WREADY),
    .wdata_i       (WDATA),
    .wstrb_i       (WSTRB),
    .bvalid_o      (BVALID),
    .bready_i      (BREADY),
    .bresp_o       (BRESP),
    .commit_ok_o   (commit_ok_s),
    .commit_idx_o  (commit_idx_s),
    .commit_data_o (commit_data_s),
    .commit_strb_o (commit_strb_s)
  );

  assign merged_full_s = apply_wstrb(MAX_DATA_W'(regs_q[commit_idx_s]),
                                     MAX_DATA_W'(commit_data_s),
                                     (MAX_DATA_W/8)'(commit_strb_s));

  // Register array update and the one-cycle commit pulse.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (commit_ok_s) begin
        regs_q[commit_idx_s] <= merged_full_s[DATA_W-1:0];
        if (|commit_strb_s) begin
          wr_pulse_q[commit_idx_s] <= 1'b1;
        end
      end
    end
  end

  // Read decode samples the array before this edge's write lands, so a same-edge read sees old data.
  always_comb begin
    ar_hs_s       = ARVALID && arready_q;
    ar_word_s     = ARADDR >> LSB;
    ar_idx_s      = ar_word_s[IDX_W-1:0];
    ar_in_range_s = (ar_word_s < ADDR_W'(NUM_REGS));
    if (RO_MASK[ar_idx_s]) begin
      rd_val_s = hw_s[ar_idx_s];
    end else begin
      rd_val_s = regs_q[ar_idx_s];
    end
  end

  // Read FSM: response registered on the AR handshake edge and held until RREADY.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (ar_hs_s) begin
            rd_state_q <= R_RESP;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rdata_q    <= ar_in_range_s ? rd_val_s : '0;
            rresp_q    <= ar_in_range_s ? RESP_OKAY : RESP_SLVERR;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_RESP: begin
          if (RREADY) begin
            rd_state_q <= R_IDLE;
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
          end
        end
        default: begin
          rd_state_q <= R_IDLE;
          arready_q  <= 1'b0;
          rvalid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ARREADY    = arready_q;
  assign RVALID     = rvalid_q;
  assign RDATA      = rdata_q;
  assign RRESP      = rresp_q;
  assign wr_pulse_o = wr_pulse_q;

  logic unused_s;
  assign unused_s = ^{AWPROT, ARPROT, merged_full_s};

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Self-checking bench for axil_slave_regfile (16 x 32-bit, reg 3 read-only).
module tb_axil_slave_regfile;

  localparam int NR = 16;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic            AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic            ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0]     AWADDR, ARADDR, WDATA, RDATA;
  logic [2:0]      AWPROT, ARPROT;
  logic [3:0]      WSTRB;
  logic [1:0]      BRESP, RRESP;
  logic [NR*32-1:0] regs_o, hw_rd_data_i;
  logic [NR-1:0]   wr_pulse_o;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        ew, er;
  logic [31:0] model [NR];
  int          errors = 0;
  int          checks = 0;

  always #5 ACLK = ~ACLK;

  axil_slave_regfile #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .NUM_REGS (NR),
    .RO_MASK  (16'h0008)
  ) dut (
    .ACLK (ACLK), .ARESET (ARESET),
    .AWVALID (AWVALID), .AWREADY (AWREADY), .AWADDR (AWADDR), .AWPROT (AWPROT),
    .WVALID (WVALID), .WREADY (WREADY), .WDATA (WDATA), .WSTRB (WSTRB),
    .BVALID (BVALID), .BREADY (BREADY), .BRESP (BRESP),
    .ARVALID (ARVALID), .ARREADY (ARREADY), .ARADDR (ARADDR), .ARPROT (ARPROT),
    .RVALID (RVALID), .RREADY (RREADY), .RDATA (RDATA), .RRESP (RRESP),
    .regs_o (regs_o), .hw_rd_data_i (hw_rd_data_i), .wr_pulse_o (wr_pulse_o)
  );

  function automatic logic [NR*32-1:0] model_flat();
    logic [NR*32-1:0] f;
    for (int i = 0; i < NR; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  task automatic drv_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output int lat, output logic [15:0] pulse,
                           output logic got);
    logic aw_done, w_done, aw_hs, w_hs;
    int n;
    @(negedge ACLK);
    AWVALID = 1'b1; AWADDR = addr; WVALID = 1'b1; WDATA = data; WSTRB = strb;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      @(negedge ACLK); n++;
      if (aw_hs) begin AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin WVALID = 1'b0;  w_done = 1'b1;  end
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    lat = 0;
    while (!BVALID && lat < 50) begin @(negedge ACLK); lat++; end
    resp = BRESP; pulse = wr_pulse_o; got = BVALID;
    if (got) @(negedge ACLK);
  endtask

  task automatic drv_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output logic got);
    logic hs, done;
    int n;
    @(negedge ACLK);
    ARVALID = 1'b1; ARADDR = addr; done = 1'b0; n = 0;
    while (!done && n < 50) begin
      hs = ARREADY;
      @(negedge ACLK); n++;
      if (hs) begin ARVALID = 1'b0; done = 1'b1; end
    end
    ARVALID = 1'b0; n = 0;
    while (!RVALID && n < 50) begin @(negedge ACLK); n++; end
    data = RDATA; resp = RRESP; got = RVALID;
    if (got) @(negedge ACLK);
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0; BREADY = 1'b1; RREADY = 1'b1;
    AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0; AWPROT = 3'd0; ARPROT = 3'd0;
    hw_rd_data_i = {NR{32'h5A5A_5A5A}};
    hw_rd_data_i[3*32 +: 32] = 32'h0000_CAFE;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    repeat (3) @(negedge ACLK);
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake: got %b want 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    checks++;
    if ({BRESP, RRESP, RDATA, wr_pulse_o} !== 52'h0) begin
      errors++; $display("FAIL reset_resp: got %h want 0", {BRESP, RRESP, RDATA, wr_pulse_o});
    end
    checks++;
    if (regs_o !== model_flat()) begin errors++; $display("FAIL reset_regs: got %h want 0", regs_o); end
    ARESET = 1'b0;
    #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
      errors++; $display("FAIL ready_at_release: got %b want 000", {AWREADY, WREADY, ARREADY});
    end
    @(negedge ACLK);
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      errors++; $display("FAIL ready_after_release: got %b want 111", {AWREADY, WREADY, ARREADY});
    end
  endtask

  task automatic test_write_same_cycle();
    logic [1:0] resp; int lat; logic [15:0] pulse; logic got;
    model[2] = 32'hDEAD_BEEF;
    exp_q.push_back('{data: 32'hDEAD_BEEF, resp: 2'b00});
    drv_write(32'h08, 32'hDEAD_BEEF, 4'hF, resp, lat, pulse, got);
    ew = exp_q.pop_front();
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL same_cycle_bvalid: got %b want 1", got); end
    checks++; if (lat !== 0) begin errors++; $display("FAIL same_cycle_latency: got %0d want 0", lat); end
    checks++; if (resp !== ew.resp) begin errors++; $display("FAIL same_cycle_bresp: got %b want %b", resp, ew.resp); end
    checks++; if (pulse !== 16'h0004) begin errors++; $display("FAIL same_cycle_pulse: got %h want 0004", pulse); end
    checks++; if (regs_o[2*32 +: 32] !== ew.data) begin
      errors++; $display("FAIL same_cycle_reg2: got %h want %h", regs_o[2*32 +: 32], ew.data);
    end
    checks++; if (wr_pulse_o !== 16'h0) begin errors++; $display("FAIL same_cycle_pulse_clear: got %h want 0", wr_pulse_o); end
  endtask

  task automatic test_w_before_aw();
    model[1] = 32'hA5A5_0001;
    exp_q.push_back('{data: 32'hA5A5_0001, resp: 2'b00});
    @(negedge ACLK);
    WVALID = 1'b1; WDATA = 32'hA5A5_0001; WSTRB = 4'hF;
    @(negedge ACLK);
    WVALID = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({WREADY, BVALID} !== 2'b00) begin
        errors++; $display("FAIL w_first_wait: cycle %0d got wready,bvalid=%b want 00", c, {WREADY, BVALID});
      end
      if (c < 2) @(negedge ACLK);
    end
    AWVALID = 1'b1; AWADDR = 32'h04;
    @(negedge ACLK);
    AWVALID = 1'b0;
    ew = exp_q.pop_front();
    checks++; if ({BVALID, BRESP} !== {1'b1, ew.resp}) begin
      errors++; $display("FAIL w_first_bresp: got %b want %b", {BVALID, BRESP}, {1'b1, ew.resp});
    end
    checks++; if (regs_o[1*32 +: 32] !== ew.data) begin
      errors++; $display("FAIL w_first_reg1: got %h want %h", regs_o[1*32 +: 32], ew.data);
    end
    checks++; if (wr_pulse_o !== 16'h0002) begin errors++; $display("FAIL w_first_pulse: got %h want 0002", wr_pulse_o); end
    @(negedge ACLK);
    checks++; if ({BVALID, wr_pulse_o} !== 17'h0) begin
      errors++; $display("FAIL w_first_once: got %h want 0", {BVALID, wr_pulse_o});
    end
    checks++; if (regs_o !== model_flat()) begin errors++; $display("FAIL w_first_regs: got %h want %h", regs_o, model_flat()); end
  endtask

  task automatic test_strobe();
    logic [1:0] resp; int lat; logic [15:0] pulse; logic got; logic [31:0] rd;
    model[0] = 32'h1122_3344;
    drv_write(32'h00, 32'h1122_3344, 4'hF, resp, lat, pulse, got);
    model[0] = 32'h11BB_33DD;
    exp_q.push_back('{data: 32'h11BB_33DD, resp: 2'b00});
    drv_write(32'h00, 32'hAABB_CCDD, 4'b0101, resp, lat, pulse, got);
    ew = exp_q.pop_front();
    checks++; if ({got, resp} !== {1'b1, ew.resp}) begin errors++; $display("FAIL strobe_bresp: got %b want %b", {got, resp}, {1'b1, ew.resp}); end
    checks++; if (regs_o[31:0] !== ew.data) begin errors++; $display("FAIL strobe_reg0: got %h want %h", regs_o[31:0], ew.data); end
    exp_q.push_back('{data: 32'h11BB_33DD, resp: 2'b00});
    drv_write(32'h00, 32'hFFFF_FFFF, 4'h0, resp, lat, pulse, got);
    ew = exp_q.pop_front();
    checks++; if ({got, resp, pulse} !== {1'b1, ew.resp, 16'h0}) begin
      errors++; $display("FAIL zero_strb: got %h want %h", {got, resp, pulse}, {1'b1, ew.resp, 16'h0});
    end
    checks++; if (regs_o !== model_flat()) begin errors++; $display("FAIL zero_strb_regs: got %h want %h", regs_o, model_flat()); end
    exp_q.push_back('{data: 32'h11BB_33DD, resp: 2'b00});
    drv_read(32'h00, rd, resp, got);
    er = exp_q.pop_front();
    checks++; if ({got, resp, rd} !== {1'b1, er.resp, er.data}) begin
      errors++; $display("FAIL strobe_read: got %h want %h", {got, resp, rd}, {1'b1, er.resp, er.data});
    end
    exp_q.push_back('{data: 32'hDEAD_BEEF, resp: 2'b00});
    drv_read(32'h0A, rd, resp, got);
    er = exp_q.pop_front();
    checks++; if ({got, resp, rd} !== {1'b1, er.resp, er.data}) begin
      errors++; $display("FAIL unaligned_read: got %h want %h", {got, resp, rd}, {1'b1, er.resp, er.data});
    end
  endtask

  task automatic test_bad_access();
    logic [1:0] resp; int lat; logic [15:0] pulse; logic got; logic [31:0] rd;
    exp_q.push_back('{data: 32'h0, resp: 2'b10});
    drv_write(32'h40, 32'h0000_00FF, 4'hF, resp, lat, pulse, got);
    ew = exp_q.pop_front();
    checks++; if ({got, resp, pulse} !== {1'b1, ew.resp, 16'h0}) begin
      errors++; $display("FAIL oor_write: got %h want %h", {got, resp, pulse}, {1'b1, ew.resp, 16'h0});
    end
    exp_q.push_back('{data: 32'h0, resp: 2'b10});
    drv_read(32'h40, rd, resp, got);
    er = exp_q.pop_front();
    checks++; if ({got, resp, rd} !== {1'b1, er.resp, er.data}) begin
      errors++; $display("FAIL oor_read: got %h want %h", {got, resp, rd}, {1'b1, er.resp, er.data});
    end
    model[15] = 32'h0F0F_000F;
    exp_q.push_back('{data: 32'h0F0F_000F, resp: 2'b00});
    drv_write(32'h3C, 32'h0F0F_000F, 4'hF, resp, lat, pulse, got);
    ew = exp_q.pop_front();
    checks++; if ({got, resp, pulse} !== {1'b1, ew.resp, 16'h8000}) begin
      errors++; $display("FAIL last_reg_write: got %h want %h", {got, resp, pulse}, {1'b1, ew.resp, 16'h8000});
    end
    exp_q.push_back('{data: 32'h0, resp: 2'b10});
    drv_write(32'h0C, 32'h1234_5678, 4'hF, resp, lat, pulse, got);
    ew = exp_q.pop_front();
    checks++; if ({got, resp, pulse} !== {1'b1, ew.resp, 16'h0}) begin
      errors++; $display("FAIL ro_write: got %h want %h", {got, resp, pulse}, {1'b1, ew.resp, 16'h0});
    end
    checks++; if (regs_o !== model_flat()) begin errors++; $display("FAIL bad_access_regs: got %h want %h", regs_o, model_flat()); end
    exp_q.push_back('{data: 32'h0000_CAFE, resp: 2'b00});
    drv_read(32'h0C, rd, resp, got);
    er = exp_q.pop_front();
    checks++; if ({got, resp, rd} !== {1'b1, er.resp, er.data}) begin
      errors++; $display("FAIL ro_read: got %h want %h", {got, resp, rd}, {1'b1, er.resp, er.data});
    end
  endtask

  task automatic test_same_edge();
    exp_q.push_back('{data: 32'h0BAD_F00D, resp: 2'b00});
    exp_q.push_back('{data: model[5], resp: 2'b00});
    model[5] = 32'h0BAD_F00D;
    @(negedge ACLK);
    AWVALID = 1'b1; AWADDR = 32'h14; WVALID = 1'b1; WDATA = 32'h0BAD_F00D; WSTRB = 4'hF;
    ARVALID = 1'b1; ARADDR = 32'h14;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    ew = exp_q.pop_front();
    er = exp_q.pop_front();
    checks++; if ({BVALID, BRESP, RVALID, RRESP, RDATA} !== {1'b1, ew.resp, 1'b1, er.resp, er.data}) begin
      errors++; $display("FAIL same_edge_read: got %h want %h", {BVALID, BRESP, RVALID, RRESP, RDATA},
                         {1'b1, ew.resp, 1'b1, er.resp, er.data});
    end
    checks++; if (regs_o[5*32 +: 32] !== ew.data) begin
      errors++; $display("FAIL same_edge_reg5: got %h want %h", regs_o[5*32 +: 32], ew.data);
    end
    @(negedge ACLK);
  endtask

  task automatic test_backpressure();
    model[7] = 32'h7777_0007;
    exp_q.push_back('{data: 32'h7777_0007, resp: 2'b00});
    exp_q.push_back('{data: model[2], resp: 2'b00});
    @(negedge ACLK);
    BREADY = 1'b0; RREADY = 1'b0;
    AWVALID = 1'b1; AWADDR = 32'h1C; WVALID = 1'b1; WDATA = 32'h7777_0007; WSTRB = 4'hF;
    ARVALID = 1'b1; ARADDR = 32'h08;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    ew = exp_q.pop_front();
    er = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({BVALID, BRESP, RVALID, RRESP, RDATA, AWREADY, WREADY, ARREADY} !==
          {1'b1, ew.resp, 1'b1, er.resp, er.data, 3'b000}) begin
        errors++; $display("FAIL backpressure_hold: cycle %0d got %h want %h", c,
                           {BVALID, BRESP, RVALID, RRESP, RDATA, AWREADY, WREADY, ARREADY},
                           {1'b1, ew.resp, 1'b1, er.resp, er.data, 3'b000});
      end
      @(negedge ACLK);
    end
    BREADY = 1'b1; RREADY = 1'b1;
    @(negedge ACLK);
    checks++; if ({BVALID, RVALID, AWREADY, WREADY, ARREADY} !== 5'b00111) begin
      errors++; $display("FAIL backpressure_release: got %b want 00111", {BVALID, RVALID, AWREADY, WREADY, ARREADY});
    end
    checks++; if (regs_o !== model_flat()) begin errors++; $display("FAIL backpressure_regs: got %h want %h", regs_o, model_flat()); end
  endtask

  task automatic test_reset_mid();
    @(negedge ACLK);
    AWVALID = 1'b1; AWADDR = 32'h10;
    @(negedge ACLK);
    AWVALID = 1'b0;
    checks++; if ({AWREADY, WREADY} !== 2'b01) begin
      errors++; $display("FAIL mid_aw_held: got %b want 01", {AWREADY, WREADY});
    end
    ARESET = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA, wr_pulse_o} !== 57'h0) begin
      errors++; $display("FAIL mid_reset_outputs: got %h want 0",
                         {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA, wr_pulse_o});
    end
    checks++; if (regs_o !== model_flat()) begin errors++; $display("FAIL mid_reset_regs: got %h want 0", regs_o); end
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    WVALID = 1'b1; WDATA = 32'h0000_0055; WSTRB = 4'hF;
    @(negedge ACLK);
    WVALID = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({BVALID, wr_pulse_o} !== 17'h0) begin
        errors++; $display("FAIL no_stale_commit: cycle %0d got %h want 0", c, {BVALID, wr_pulse_o});
      end
      @(negedge ACLK);
    end
    model[6] = 32'h0000_0055;
    exp_q.push_back('{data: 32'h0000_0055, resp: 2'b00});
    AWVALID = 1'b1; AWADDR = 32'h18;
    @(negedge ACLK);
    AWVALID = 1'b0;
    ew = exp_q.pop_front();
    checks++; if ({BVALID, BRESP, wr_pulse_o} !== {1'b1, ew.resp, 16'h0040}) begin
      errors++; $display("FAIL post_reset_write: got %h want %h", {BVALID, BRESP, wr_pulse_o}, {1'b1, ew.resp, 16'h0040});
    end
    checks++; if (regs_o !== model_flat()) begin errors++; $display("FAIL post_reset_regs: got %h want %h", regs_o, model_flat()); end
    @(negedge ACLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_strobe();
    test_bad_access();
    test_same_edge();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
